// File: rtl/pad_pkg.sv
// Shared definitions for the stream_padder block: FSM state type and counter sizing.
package pad_pkg;

  typedef enum logic [1:0] {
    PAD_IDLE  = 2'd0,
    PAD_RUN   = 2'd1,
    PAD_DRAIN = 2'd2
  } pad_state_e;

  // A single-position map still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster row/column counter over the padded map, with interior/eol/eof decodes.
module pad_pos_counter
  import pad_pkg::*;
#(
  parameter int OUT_SIZE = 16,
  parameter int LO       = 1,
  parameter int HI       = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic advance_i,
  output logic interior_o,
  output logic last_interior_o,
  output logic eol_o,
  output logic eof_o
);

  localparam int CW = cnt_width(OUT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] LO_C = CW'(LO);
  localparam logic [CW-1:0] HI_C = CW'(HI);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_lo_ok, col_lo_ok;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // With no border the lower interior bound is trivially met.
  if (LO == 0) begin : g_lo_zero
    assign row_lo_ok = 1'b1;
    assign col_lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign row_lo_ok = (row_q >= LO_C);
    assign col_lo_ok = (col_q >= LO_C);
  end

  assign interior_o      = row_lo_ok && col_lo_ok && (row_q <= HI_C) && (col_q <= HI_C);
  assign last_interior_o = (row_q == HI_C) && (col_q == HI_C);
  assign eol_o           = (col_q == LAST);
  assign eof_o           = eol_o && (row_q == LAST);

endmodule

// File: rtl/stream_padder.sv
// Streaming zero/constant padder for raster feature maps with valid/ready on both sides.
// Optional in_last framing check is enabled by defining PAD_LAST_CHECK_EN.
module stream_padder
  import pad_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int CHANNELS = 1,
  parameter int IN_SIZE  = 14,
  parameter int PAD      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_W-1:0]            pad_value,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int OUT_SIZE = IN_SIZE + 2 * PAD;
  localparam int BW       = CHANNELS * DATA_W;

  pad_state_e          state_q, state_d;
  logic [DATA_W-1:0]   pad_q;
  logic                out_valid_q;
  logic [BW-1:0]       out_data_q;
  logic                out_eol_q, out_eof_q;
  logic                done_q;

  logic                interior, last_interior, eol, eof;
  logic                start_acc, slot_free, load;
  logic [BW-1:0]       pad_beat;

  // A start arriving alongside done belongs to the frame that just ended.
  assign start_acc = (state_q == PAD_IDLE) && start && !done_q;
  assign slot_free = !out_valid_q || out_ready;
  assign load      = (state_q == PAD_RUN) && slot_free && (!interior || in_valid);
  assign in_ready  = (state_q == PAD_RUN) && interior && slot_free;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pad_lane
    assign pad_beat[gi*DATA_W +: DATA_W] = pad_q;
  end

  pad_pos_counter #(
    .OUT_SIZE (OUT_SIZE),
    .LO       (PAD),
    .HI       (PAD + IN_SIZE - 1)
  ) u_pos (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (start_acc),
    .advance_i       (load),
    .interior_o      (interior),
    .last_interior_o (last_interior),
    .eol_o           (eol),
    .eof_o           (eof)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAD_IDLE:  if (start_acc) state_d = PAD_RUN;
      PAD_RUN:   if (load && eof) state_d = PAD_DRAIN;
      PAD_DRAIN: if (out_valid_q && out_ready) state_d = PAD_IDLE;
      default:   state_d = PAD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PAD_IDLE;
      pad_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == PAD_DRAIN) && out_valid_q && out_ready;
      if (start_acc) pad_q <= pad_value;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= interior ? in_data : pad_beat;
        out_eol_q   <= eol;
        out_eof_q   <= eof;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef PAD_LAST_CHECK_EN
  logic err_q;

  // in_last must be high exactly on the last interior pixel of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid && in_ready && (in_last != last_interior)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_last_check;
  assign unused_last_check = in_last ^ last_interior;
  assign err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign busy      = (state_q != PAD_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_stream_padder.sv
// Bench for stream_padder: two configurations checked against a frame-level model.
module tb_stream_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        a_start, a_iv, a_ir, a_il, a_ov, a_or, a_eol, a_eof, a_busy, a_done, a_err;
  logic [3:0]  a_pad, a_id, a_od;
  logic        b_start, b_iv, b_ir, b_il, b_ov, b_or, b_eol, b_eof, b_busy, b_done, b_err;
  logic [3:0]  b_pad;
  logic [11:0] b_id, b_od;

  stream_padder #(.DATA_W(4), .CHANNELS(1), .IN_SIZE(14), .PAD(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .pad_value(a_pad),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_last(a_il),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_eol(a_eol), .out_eof(a_eof), .busy(a_busy), .done(a_done), .err(a_err)
  );

  stream_padder #(.DATA_W(4), .CHANNELS(3), .IN_SIZE(4), .PAD(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .pad_value(b_pad),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_last(b_il),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_eol(b_eol), .out_eof(b_eof), .busy(b_busy), .done(b_done), .err(b_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tmo_cnt  = 0;
  int test_id  = 0;
  bit finish_req = 1'b0;

  function automatic int cfg_in(input int id);  return (id == 0) ? 14 : 4; endfunction
  function automatic int cfg_pad(input int id); return (id == 0) ? 1 : 2;  endfunction
  function automatic int cfg_ch(input int id);  return (id == 0) ? 1 : 3;  endfunction
  function automatic int cfg_out(input int id); return cfg_in(id) + 2 * cfg_pad(id); endfunction

  // Input element j, lane l carries (j*CHANNELS + l) mod 16.
  function automatic logic [11:0] in_elem(input int id, input int j);
    logic [11:0] v = '0;
    for (int l = 0; l < cfg_ch(id); l++) v[l*4 +: 4] = 4'((j * cfg_ch(id) + l) % 16);
    return v;
  endfunction

  function automatic bit is_interior(input int id, input int k);
    int o = cfg_out(id); int p = cfg_pad(id); int n = cfg_in(id);
    int r = k / o; int c = k % o;
    return (r >= p) && (r < p + n) && (c >= p) && (c < p + n);
  endfunction

  function automatic logic [11:0] exp_beat(input int id, input int k, input logic [3:0] pv);
    int o = cfg_out(id); int p = cfg_pad(id); int n = cfg_in(id);
    logic [11:0] v = '0;
    if (is_interior(id, k)) return in_elem(id, (k / o - p) * n + (k % o - p));
    for (int l = 0; l < cfg_ch(id); l++) v[l*4 +: 4] = pv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state per DUT, advanced once per cycle at the falling edge.
  int          m_beat[2] = '{0, 0};
  int          m_in[2]   = '{0, 0};
  int          m_c0[2]   = '{0, 0};
  logic        m_busy[2] = '{1'b0, 1'b0};
  logic        m_done[2] = '{1'b0, 1'b0};
  logic        m_err[2]  = '{1'b0, 1'b0};
  logic        m_hold[2] = '{1'b0, 1'b0};
  logic        m_rst[2]  = '{1'b0, 1'b0};
  logic [11:0] m_pd[2];
  logic        m_peol[2], m_peof[2];
  logic [3:0]  m_pad[2];

  task automatic mon(input int id, input logic r, input logic st, input logic [3:0] pv,
                     input logic iv, input logic ir, input logic il,
                     input logic ov, input logic ordy, input logic [11:0] od,
                     input logic eol, input logic eof, input logic bsy,
                     input logic dn, input logic er);
    int o = cfg_out(id);
    int n_out = o * o;
    int k;
    bit fin = 1'b0;
    if (r) begin
      m_beat[id] = 0; m_in[id] = 0; m_busy[id] = 0; m_done[id] = 0;
      m_err[id] = 0; m_hold[id] = 0; m_rst[id] = 1;
    end else begin
      if (m_rst[id]) begin
        chk($sformatf("rst_ov%0d", id), {11'b0, ov}, 12'd0);
        chk($sformatf("rst_ir%0d", id), {11'b0, ir}, 12'd0);
        chk($sformatf("rst_data%0d", id), od, 12'd0);
        chk($sformatf("rst_flags%0d", id), {9'b0, eol, eof, bsy}, 12'd0);
        m_rst[id] = 0;
      end
      chk($sformatf("busy%0d", id), {11'b0, bsy}, {11'b0, m_busy[id]});
      chk($sformatf("done%0d", id), {11'b0, dn}, {11'b0, m_done[id]});
      chk($sformatf("err%0d", id), {11'b0, er}, {11'b0, m_err[id]});
      if (m_hold[id]) begin
        chk($sformatf("hold_valid%0d", id), {11'b0, ov}, 12'd1);
        chk($sformatf("hold_data%0d", id), od, m_pd[id]);
        chk($sformatf("hold_flags%0d", id), {10'b0, eol, eof}, {10'b0, m_peol[id], m_peof[id]});
      end
      if (!m_busy[id]) begin
        chk($sformatf("idle_ov%0d", id), {11'b0, ov}, 12'd0);
        chk($sformatf("idle_ir%0d", id), {11'b0, ir}, 12'd0);
      end
      if (ir === 1'b1)
        chk($sformatf("inrdy_border%0d", id), {11'b0, is_interior(id, m_beat[id] + int'(ov))}, 12'd1);
      if (ov && ordy) begin
        k = m_beat[id];
        if (k >= n_out) begin
          chk($sformatf("extra_beat%0d", id), 12'(k), 12'(n_out - 1));
        end else begin
          chk($sformatf("data%0d_b%0d", id, k), od, exp_beat(id, k, m_pad[id]));
          chk($sformatf("eol%0d_b%0d", id, k), {11'b0, eol}, {11'b0, (k % o) == o - 1});
          chk($sformatf("eof%0d_b%0d", id, k), {11'b0, eof}, {11'b0, k == n_out - 1});
          fin = (k == n_out - 1);
        end
        if (id == 0 && test_id == 1) begin
          if (k == 0)   chk("lit_a_b0", od, 12'h000);
          if (k == 17)  chk("lit_a_b17", od, 12'h000);
          if (k == 18)  chk("lit_a_b18", od, 12'h001);
          if (k == 255) chk("lit_a_eof255", {11'b0, eof}, 12'd1);
        end
        if (id == 1 && test_id == 2) begin
          if (k == 0)  chk("lit_b_b0", od, 12'hAAA);
          if (k == 7)  chk("lit_b_eol7", {11'b0, eol}, 12'd1);
          if (k == 18) chk("lit_b_b18", od, 12'h210);
          if (k == 19) chk("lit_b_b19", od, 12'h543);
          if (k == 63) chk("lit_b_b63", {eof, od[10:0]}, 12'hAAA);
        end
        m_beat[id] = k + 1;
      end
      if (iv && ir) begin
`ifdef PAD_LAST_CHECK_EN
        if (il != (m_in[id] == cfg_in(id) * cfg_in(id) - 1)) m_err[id] = 1'b1;
`endif
        m_in[id]++;
      end
      if (dn) begin
        chk($sformatf("frame_beats%0d", id), 12'(m_beat[id]), 12'(n_out));
        if (id == 0 && test_id == 1) chk("done_cycle_a", 12'(cyc - m_c0[id]), 12'd258);
        if (id == 1 && test_id == 2) chk("done_cycle_b", 12'(cyc - m_c0[id]), 12'd66);
      end
      if (st && !m_busy[id] && !m_done[id]) begin
        m_busy[id] = 1; m_pad[id] = pv; m_beat[id] = 0; m_in[id] = 0; m_c0[id] = cyc;
      end else if (fin) begin
        m_busy[id] = 0;
      end
      m_done[id] = fin;
      m_hold[id] = ov && !ordy;
      m_pd[id] = od; m_peol[id] = eol; m_peof[id] = eof;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("no_timeout", 12'(tmo_cnt), 12'd0);
      mon(0, rst, a_start, a_pad, a_iv, a_ir, a_il, a_ov, a_or, {8'b0, a_od},
          a_eol, a_eof, a_busy, a_done, a_err);
      mon(1, rst, b_start, b_pad, b_iv, b_ir, b_il, b_ov, b_or, b_od,
          b_eol, b_eof, b_busy, b_done, b_err);
      if (finish_req) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  task automatic set_start(input int id, input logic v, input logic [3:0] pv);
    if (id == 0) begin a_start = v; a_pad = pv; end
    else         begin b_start = v; b_pad = pv; end
  endtask

  task automatic set_in(input int id, input logic v, input logic [11:0] d, input logic last, input logic rdy);
    if (id == 0) begin a_iv = v; a_id = d[3:0]; a_il = last; a_or = rdy; end
    else         begin b_iv = v; b_id = d;      b_il = last; b_or = rdy; end
  endtask

  task automatic run_frame(input int id, input logic [3:0] pv, input bit stall,
                           input int rst_at, input bit extra_start, input bit inj);
    int idx = 0; int outs = 0; int budget = 0; bit fin = 0;
    int n_in = cfg_in(id) * cfg_in(id);
    bit acc, oacc, dn;
    @(posedge clk); #1;
    set_start(id, 1'b1, pv);
    set_in(id, stall ? 1'($urandom_range(0, 1)) : 1'b1, in_elem(id, idx),
           (idx == n_in - 1) || (inj && idx == 5), stall ? 1'($urandom_range(0, 1)) : 1'b1);
    while (!fin && budget < 5000) begin
      @(negedge clk);
      acc  = (id == 0) ? (a_iv && a_ir) : (b_iv && b_ir);
      oacc = (id == 0) ? (a_ov && a_or) : (b_ov && b_or);
      dn   = (id == 0) ? a_done : b_done;
      if (extra_start && dn) set_start(id, 1'b1, pv);
      @(posedge clk); #1;
      budget++;
      set_start(id, extra_start && budget == 10, pv);
      if (acc) idx++;
      if (oacc) outs++;
      if (dn) fin = 1;
      if (rst_at > 0 && outs == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1;
      end
      set_in(id, stall ? 1'($urandom_range(0, 1)) : 1'b1, in_elem(id, idx),
             (idx == n_in - 1) || (inj && idx == 5), stall ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    if (!fin) begin
      $display("FAIL frame_timeout: dut %0d produced no done within %0d cycles", id, budget);
      tmo_cnt++;
    end
    set_start(id, 1'b0, pv);
    set_in(id, 1'b0, '0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_start(0, 1'b0, 4'h0); set_in(0, 1'b0, '0, 1'b0, 1'b1);
    set_start(1, 1'b0, 4'h0); set_in(1, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    test_id = 1; run_frame(0, 4'h0, 1'b0, 0, 1'b0, 1'b0);
    test_id = 2; run_frame(1, 4'hA, 1'b0, 0, 1'b0, 1'b0);
    test_id = 3; run_frame(0, 4'h5, 1'b1, 0, 1'b1, 1'b0);
    test_id = 4; run_frame(0, 4'h3, 1'b0, 0, 1'b0, 1'b1);
    test_id = 5; run_frame(0, 4'h7, 1'b0, 100, 1'b0, 1'b0);
    test_id = 6; run_frame(0, 4'h9, 1'b1, 0, 1'b0, 1'b0);
    test_id = 7; run_frame(1, 4'h6, 1'b1, 0, 1'b1, 1'b0);
    finish_req = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL no_finish: monitor did not end the run");
    $fatal(1, "monitor did not end the run");
  end

endmodule

// File: doc/stream_padder.md
# stream_padder

Streaming, parametrised successor to the flattened-matrix padding block in the CNN-on-FPGA datapath. It accepts an IN_SIZE×IN_SIZE feature map as a raster-order pixel stream with CHANNELS parallel lanes per beat. It emits the (IN_SIZE+2·PAD)² padded map in raster order, with a runtime pad constant. It sits between the feature-map buffer and the convolution window generator, and uses valid/ready handshakes so no frame-wide register is needed.

## Interface
- DATA_W, 4: bits per channel element
- CHANNELS, 1: parallel channels per beat
- IN_SIZE, 14: input map height and width
- PAD, 1: border width on every side, ≥0; localparam OUT_SIZE = IN_SIZE+2·PAD
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start request, sampled only in IDLE
- pad_value  in  DATA_W  border constant, latched on accepted start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- in_data  in  CHANNELS·DATA_W  channel c at [c·DATA_W +: DATA_W]
- in_last  in  1  marks final input beat of frame
- out_valid  out  1  output beat valid (registered)
- out_ready  in  1  downstream accept
- out_data  out  CHANNELS·DATA_W  padded pixel, same lane layout
- out_eol  out  1  beat is last column of an output row
- out_eof  out  1  beat is final beat of frame
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when final beat accepted
- err  out  1  sticky framing error

## Operation
- FSM states: IDLE → RUN → DRAIN → IDLE.
  - IDLE: start=1 latches pad_value, clears row/col to 0, goes to RUN.
- RUN generates position (r,c) over OUT_SIZE×OUT_SIZE.
  - Interior: PAD≤r<PAD+IN_SIZE and PAD≤c<PAD+IN_SIZE.
  - Interior beats are sourced from in_data.
  - Border beats are pad_value replicated across all CHANNELS.
- Output register loads when (!out_valid | out_ready) and the source is available.
  - Border source: always available.
  - Interior source: available when in_valid=1.
- in_ready = RUN & interior & (!out_valid | out_ready); in_ready is 0 on border positions and outside RUN.
- On each load: c increments; at c=OUT_SIZE-1, c wraps to 0 and r increments.
- Loading (OUT_SIZE-1, OUT_SIZE-1) moves the FSM to DRAIN.
- DRAIN: when the held beat is accepted, done=1 for one cycle and the FSM returns to IDLE.
- out_eol=1 on every beat with c=OUT_SIZE-1; out_eof=1 only on the final beat.
- Output register holds data and flags stable while out_valid & !out_ready.
- start outside IDLE is ignored; start in the same cycle as done is ignored; the next start is accepted in IDLE.
- PAD=0 gives a pure passthrough with eol/eof markers.
- Counter width is $clog2(OUT_SIZE); no arithmetic overflow is possible.

## Timing
- Reset values: out_valid=0, in_ready=0, out_data=0, out_eol=0, out_eof=0, busy=0, done=0, err=0, state IDLE, counters 0.
- Reset mid-frame aborts the frame and discards the held beat; no done pulse is issued.
- start high in cycle 0 → busy in cycle 1 → first out_valid in cycle 2.
- With in_valid and out_ready held high, throughput is one beat per cycle with no bubbles at border/interior transitions.
  - Beats occupy cycles 2..OUT_SIZE²+1.
  - done fires in cycle OUT_SIZE²+2.
- Latency from input acceptance to out_valid is 1 cycle.
- in_ready depends combinationally on out_ready and state only; it never depends on in_valid.

## Configuration
- PAD_LAST_CHECK_EN defined: in_last is compared on every accepted input beat.
  - err sets and stays set until rst if in_last=1 on any non-final interior beat.
  - err also sets if in_last=0 on the final interior beat (r=c=PAD+IN_SIZE-1).
- Undefined: in_last is ignored and err is tied to 0. Ports are present in both builds.

## Structure
- Shared package pad_pkg holds:
  - the state typedef (PAD_IDLE, PAD_RUN, PAD_DRAIN);
  - the counter-width function.
- One sub-module, pad_pos_counter:
  - row/col counter with advance input;
  - interior, eol and eof decode outputs.
- Top level holds the FSM, output register and check logic.

## Test plan
- Defaults, pad_value=0, input element k = k mod 16, in_valid/out_ready=1:
  - 256 beats, all row 0 and row 15 beats = 0, beat (1,1) = element 0;
  - done in cycle 258, err=0.
- pad_value=4'hA, CHANNELS=3, IN_SIZE=4, PAD=2:
  - 64 beats with border = 12'hAAA;
  - interior equals input order;
  - out_eol on beats 7,15,…,63.
- Random out_ready (50%) and in_valid gaps:
  - output sequence identical to the no-stall case;
  - out_data is stable while stalled;
  - in_ready=0 on all border positions.
- rst asserted at beat 100 of a frame:
  - all outputs return to reset values the next cycle;
  - a new start produces a correct full frame.
- PAD_LAST_CHECK_EN builds:
  - in_last asserted on interior beat 5 → err=1 that cycle+1 and stays set;
  - correct in_last → err=0.
- start pulsed during RUN and in the done cycle → ignored; exactly one frame emitted.
